// File: rtl/mypkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mypkg: shared AES helpers (GF(2^8) arithmetic, S-boxes, expansion consts)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mypkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_expand = 2'd1;
  localparam logic [1:0] c_st_done   = 2'd2;

  localparam logic [7:0] c_rcon_init = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mult(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = mult(p, p);
      r = mult(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] subbytef(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invsubbytef(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_seq_subword.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_subword: four parallel forward S-box lookups on one 32-bit word         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_subword
  import mypkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign o_word[8*g +: 8] = subbytef(i_word[8*g +: 8]);
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_expand_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_key_expand_seq: sequential AES key expansion, one schedule word/cycle   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_key_expand_seq
  import mypkg::*;
#(
  parameter int nk = 8,
  parameter int nb = 4,
  parameter int nr = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [32*nk-1:0]          key,
  output logic                      busy,
  output logic                      done,
  output logic                      w_valid,
  output logic [32*nb*(nr+1)-1:0]   w
);

  localparam int             c_nw       = nb * (nr + 1);
  localparam int             c_iw       = $clog2(c_nw);
  localparam logic [c_iw-1:0] c_last_idx = c_iw'(c_nw - 1);
  localparam logic [2:0]     c_mod_last = 3'(nk - 1);

  logic [1:0]      state_q, state_d;
  logic [c_iw-1:0] idx_q, idx_d;
  logic [2:0]      mod_q, mod_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            w_valid_q, w_valid_d;
  logic [31:0]     words_q [c_nw];
  logic [31:0]     words_d [c_nw];

  logic [c_iw-1:0] prev_idx;
  logic [c_iw-1:0] back_idx;
  logic [31:0]     prev_word;
  logic [31:0]     back_word;
  logic [31:0]     sub_in;
  logic [31:0]     sub_out;
  logic [31:0]     temp;

  assign prev_idx  = idx_q - c_iw'(1);
  assign back_idx  = idx_q - c_iw'(nk);
  assign prev_word = words_q[prev_idx];
  assign back_word = words_q[back_idx];

  // RotWord only at the start of each nk-word group; SubWord also serves the nk=8 mid-group step.
  assign sub_in = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_subword u_subword (
    .i_word (sub_in),
    .o_word (sub_out)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mod_d     = mod_q;
    rcon_d    = rcon_q;
    w_valid_d = w_valid_q;
    words_d   = words_q;
    temp      = prev_word;

    case (state_q)
      c_st_idle: begin
        if (start) begin
          for (int j = 0; j < nk; j++) begin
            words_d[j] = key[32*(nk-1-j) +: 32];
          end
          idx_d     = c_iw'(nk);
          mod_d     = 3'd0;
          rcon_d    = c_rcon_init;
          w_valid_d = 1'b0;
          state_d   = c_st_expand;
        end
      end

      c_st_expand: begin
        if (mod_q == 3'd0) begin
          temp   = sub_out ^ {rcon_q, 24'h000000};
          rcon_d = xtime(rcon_q);
        end else if (nk == 8 && mod_q == 3'd4) begin
          temp = sub_out;
        end
        words_d[idx_q] = back_word ^ temp;
        mod_d = (mod_q == c_mod_last) ? 3'd0 : mod_q + 3'd1;
        if (idx_q == c_last_idx) begin
          state_d   = c_st_done;
          w_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + c_iw'(1);
        end
      end

      c_st_done: state_d = c_st_idle;

      default: state_d = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_st_idle;
      idx_q     <= '0;
      mod_q     <= 3'd0;
      rcon_q    <= c_rcon_init;
      w_valid_q <= 1'b0;
      for (int j = 0; j < c_nw; j++) begin
        words_q[j] <= 32'h0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mod_q     <= mod_d;
      rcon_q    <= rcon_d;
      w_valid_q <= w_valid_d;
      words_q   <= words_d;
    end
  end

  for (genvar g = 0; g < c_nw; g++) begin : g_w
    assign w[32*g +: 32] = words_q[g];
  end

  assign busy    = (state_q == c_st_expand);
  assign done    = (state_q == c_st_done);
  assign w_valid = w_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_key_expand_seq: scoreboard bench for nk = 4, 6 and 8 instances       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_key_expand_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start8 = 1'b0, start6 = 1'b0, start4 = 1'b0;
  logic [255:0]  key8 = '0;
  logic [191:0]  key6 = '0;
  logic [127:0]  key4 = '0;
  logic          busy8, done8, wv8, busy6, done6, wv6, busy4, done4, wv4;
  logic [1919:0] w8;
  logic [1663:0] w6;
  logic [1407:0] w4;

  aes_key_expand_seq #(.nk(8), .nb(4), .nr(14)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .key(key8),
    .busy(busy8), .done(done8), .w_valid(wv8), .w(w8));
  aes_key_expand_seq #(.nk(6), .nb(4), .nr(12)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .key(key6),
    .busy(busy6), .done(done6), .w_valid(wv6), .w(w6));
  aes_key_expand_seq #(.nk(4), .nb(4), .nr(10)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .key(key4),
    .busy(busy4), .done(done4), .w_valid(wv4), .w(w4));

  typedef struct {
    int            cyc;
    logic [1919:0] w;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  exp_t q4[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic [7:0] sbox [256];

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from the generator-3 walk over GF(2^8) and its inverse walk.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic logic [1919:0] model(input int nk, input logic [255:0] k);
    logic [31:0]   wd [60];
    logic [7:0]    rc [10];
    logic [31:0]   t;
    logic [1919:0] flat;
    int            nw;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nw = 4 * (nk + 7);
    flat = '0;
    for (int j = 0; j < nk; j++) wd[j] = k[32*(nk-1-j) +: 32];
    for (int i = nk; i < nw; i++) begin
      t = wd[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) flat[32*i +: 32] = wd[i];
    return flat;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_sched(input string nm, input logic [1919:0] got, input logic [1919:0] exp);
    int bad;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        if (got[32*i +: 32] !== exp[32*i +: 32]) begin
          bad = i;
          break;
        end
      end
      $display("FAIL %s: word %0d got %h, expected %h", nm, bad, got[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  task automatic judge(input string nm, input exp_t e, input logic [1919:0] got,
                       input logic b, input logic v);
    check({nm, "_done_cycle"}, cyc, e.cyc);
    check({nm, "_busy_at_done"}, {31'h0, b}, 32'h0);
    check({nm, "_wvalid_at_done"}, {31'h0, v}, 32'h1);
    check_sched({nm, "_schedule"}, got, e.w);
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got done pulse, expected none", nm);
  endtask

  // Monitors: pop one expectation per observed done pulse.
  logic          done8_prev = 1'b0;
  logic          wv8_prev   = 1'b0;
  logic [1919:0] w8_prev    = '0;

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) unexpected("nk8_done");
      else judge("nk8", q8.pop_front(), w8, busy8, wv8);
      check("nk8_done_width", {31'h0, done8_prev}, 32'h0);
    end
    if (!rst && wv8 && wv8_prev) check_sched("nk8_hold", w8, w8_prev);
    done8_prev = done8;
    wv8_prev   = wv8;
    w8_prev    = w8;
  end

  always @(negedge clk) begin
    if (!rst && done6) begin
      if (q6.size() == 0) unexpected("nk6_done");
      else judge("nk6", q6.pop_front(), {256'h0, w6}, busy6, wv6);
    end
  end

  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) unexpected("nk4_done");
      else judge("nk4", q4.pop_front(), {512'h0, w4}, busy4, wv4);
    end
  end

  // Called #1 after a rising edge; start is sampled on the next edge.
  task automatic go(input int nk, input logic [255:0] k);
    exp_t e;
    e.cyc = cyc + 1 + (4 * (nk + 7) - nk);
    e.w   = model(nk, k);
    case (nk)
      8: begin q8.push_back(e); key8 = k;          start8 = 1'b1; end
      6: begin q6.push_back(e); key6 = k[191:0];   start6 = 1'b1; end
      default: begin q4.push_back(e); key4 = k[127:0]; start4 = 1'b1; end
    endcase
    @(posedge clk); #1;
    start8 = 1'b0;
    start6 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q8.size() + q6.size() + q4.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", ((q8.size() + q6.size() + q4.size()) != 0) ? 32'h1 : 32'h0, 32'h0);
  endtask

  function automatic logic [255:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [255:0] c_k8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] c_k6 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
  localparam logic [255:0] c_k4 = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};

  initial begin
    int n;
    build_sbox();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy8}, 32'h0);
    check("rst_done", {31'h0, done8}, 32'h0);
    check("rst_wvalid", {31'h0, wv8}, 32'h0);
    check_sched("rst_w", w8, '0);

    // Start in the first cycle after reset, then hammer start/key during EXPAND.
    rst = 1'b0;
    go(8, c_k8);
    for (int i = 0; i < 25; i++) begin
      start8 = 1'b1;
      key8   = rnd_key();
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    drain(200);
    check("nk8_w59", w8[59*32 +: 32], 32'h706c631e);

    // Back-to-back: start held across DONE (ignored) and IDLE (accepted).
    go(8, rnd_key());
    n = 0;
    while (!done8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_wait_done", {31'h0, done8}, 32'h1);
    begin
      logic [255:0] kb;
      exp_t e;
      kb = rnd_key();
      start8 = 1'b1;
      key8   = kb;
      @(posedge clk); #1;
      e.cyc = cyc + 1 + 52;
      e.w   = model(8, kb);
      q8.push_back(e);
      @(posedge clk); #1;
      start8 = 1'b0;
      check("b2b_wvalid_drop", {31'h0, wv8}, 32'h0);
      check("b2b_busy", {31'h0, busy8}, 32'h1);
    end
    drain(200);

    for (int r = 0; r < 5; r++) begin
      go(8, rnd_key());
      drain(200);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset ten cycles into an expansion, then a clean restart.
    @(posedge clk); #1;
    go(8, rnd_key());
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q8.delete();
    check("midrst_busy", {31'h0, busy8}, 32'h0);
    check("midrst_done", {31'h0, done8}, 32'h0);
    check("midrst_wvalid", {31'h0, wv8}, 32'h0);
    check_sched("midrst_w", w8, '0);
    go(8, c_k8);
    drain(200);
    check("midrst_w59", w8[59*32 +: 32], 32'h706c631e);

    // Shorter key lengths.
    @(posedge clk); #1;
    go(4, c_k4);
    go(6, c_k6);
    drain(200);
    check("nk4_w4", w4[4*32 +: 32], 32'ha0fafe17);
    check("nk4_w43", w4[43*32 +: 32], 32'hb6630ca6);
    check("nk6_w51", w6[51*32 +: 32], 32'h01002202);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      go(4, rnd_key());
      go(6, rnd_key());
      drain(200);
    end

    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_expand_seq.md
AES_KEY_EXPAND_SEQ -- requirements
Module: aes_key_expand_seq

Interface
REQ-001 SHALL have parameter nk, default 8; key length in 32-bit words; legal values 4, 6 and 8.
REQ-002 SHALL have parameter nb, default 4; state width in words; fixed at 4.
REQ-003 SHALL have parameter nr, default 14; number of rounds; must equal nk+6.
REQ-004 SHALL have port clk, input, 1 bit; the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit; a one-cycle request to expand key.
REQ-007 SHALL have port key, input, 32*nk bits; cipher key with the first key byte in key[32*nk-1:32*nk-8] (FIPS-197 order).
REQ-008 SHALL have port busy, output, 1 bit; high while expansion is in progress.
REQ-009 SHALL have port done, output, 1 bit; one-cycle pulse when w is complete.
REQ-010 SHALL have port w_valid, output, 1 bit; high while w holds a complete schedule.
REQ-011 SHALL have port w, output, 32*nb*(nr+1) bits; the key schedule, with word i at w[32*i+31:32*i] and its first byte at bits [31:24]; directly compatible with the decryption block's w input.

Function
REQ-012 SHALL implement states IDLE, EXPAND and DONE.
- IDLE -> EXPAND on start=1.
- EXPAND -> DONE after the last word is written.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 On the edge sampling start=1 in IDLE, SHALL load words 0..nk-1 from key, set the word index i=nk, set rcon=8'h01, and clear w_valid.
REQ-014 In EXPAND, SHALL compute exactly one word per cycle:
- temp = word[i-1];
- if (i mod nk)==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon);
- else if nk==8 and (i mod nk)==4: temp = SubWord(temp);
- word[i] = word[i-nk] ^ temp.
REQ-015 SHALL track (i mod nk) with a wrapping counter; no divider SHALL be used.
REQ-016 The rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36, with xtime reducing by 8'h1b on overflow.
REQ-017 SHALL write the final word nb*(nr+1)-1 on the edge that enters DONE.
- done=1 and w_valid=1 become visible in the following cycle.
- Latency from the start edge to done high is nb*(nr+1)-nk cycles: 40, 46 and 52 for nk=4, 6 and 8.
REQ-018 busy SHALL be 1 exactly while in EXPAND.
REQ-019 done SHALL be high for exactly one cycle per expansion.
REQ-020 w and w_valid SHALL hold stable from done until the next accepted start or reset.
REQ-021 start while in EXPAND or DONE SHALL be ignored; key changes during EXPAND SHALL have no effect.
REQ-022 start coincident with rst SHALL be ignored.
REQ-023 Back-to-back requests SHALL be supported: a start sampled in the cycle after DONE (state IDLE) SHALL be accepted.

Reset
REQ-024 rst=1 SHALL force state IDLE, busy=0, done=0, w_valid=0, w=0, i=0 and rcon=8'h01 on the next edge, including in the middle of an expansion.
REQ-025 After rst deasserts, the block SHALL accept start in the first cycle.

Structure
REQ-026 The forward S-box function (subbytef), xtime, and the rcon initial value SHALL reside in the shared package mypkg.v alongside invsubbytef and mult.
REQ-027 A single sub-module aes_subword (4 parallel S-box lookups on one 32-bit word, combinational) SHALL be instantiated once.
REQ-028 The word store SHALL be registers, with one word written per cycle.

Verification
REQ-029 nk=4, key 2b7e151628aed2a6abf7158809cf4f3c:
- done 40 cycles after start;
- w[4]=a0fafe17, w[43]=b6630ca6.
REQ-030 nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
- done after 46 cycles;
- w[51]=01002202.
REQ-031 nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
- done after 52 cycles;
- w[59]=706c631e;
- feeding w to the decryption block with the FIPS-197 C.3 ciphertext 8ea2b7ca516745bfeafc49904b496089 yields 00112233445566778899aabbccddeeff.
REQ-032 Reset 10 cycles into an nk=8 expansion:
- next cycle busy=0, done=0, w_valid=0, w=0;
- a subsequent start completes in 52 cycles with correct w[59].
REQ-033 Ignored and back-to-back requests:
- start pulsed every cycle during EXPAND is ignored;
- exactly one done pulse results;
- a second start the cycle after DONE with a new key yields a new correct schedule, and w_valid drops at acceptance.
